// File: rtl/sub_16_bit_serial.sv
// sub_16_bit_serial: nibble-serial subtractor, diff = a - b - borrow_in, one NIBBLE slice per clock.
module sub_16_bit_serial #(
   parameter int WIDTH  = 16,
   parameter int NIBBLE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             borrow_in_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_out_o,
   output logic             overflow_o,
   output logic             out_valid_o,
   input  logic             out_ready_i
);
   localparam int NS = WIDTH / NIBBLE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              borrow_q, borrow_d, borrow_out_q, borrow_out_d, overflow_q, overflow_d;
   logic [NIBBLE-1:0] a_nib, b_nib;
   logic [NIBBLE:0]   sub;
   logic              last;

   assign a_nib = a_q[cnt_q*NIBBLE +: NIBBLE];
   assign b_nib = b_q[cnt_q*NIBBLE +: NIBBLE];
   // Top bit of the widened difference is the borrow out of this slice.
   assign sub   = {1'b0, a_nib} - {1'b0, b_nib} - {{NIBBLE{1'b0}}, borrow_q};
   assign last  = cnt_q == CW'(NS - 1);

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      cnt_d        = cnt_q;
      borrow_d     = borrow_q;
      borrow_out_d = borrow_out_q;
      overflow_d   = overflow_q;
      unique case (state_q)
         IDLE: if (in_valid_i) begin
            state_d  = CALC;
            a_d      = a_i;
            b_d      = b_i;
            borrow_d = borrow_in_i;
            cnt_d    = '0;
         end
         CALC: begin
            diff_d[cnt_q*NIBBLE +: NIBBLE] = sub[NIBBLE-1:0];
            borrow_d = sub[NIBBLE];
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
               state_d      = DONE;
               borrow_out_d = sub[NIBBLE];
               overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sub[NIBBLE-1] != a_q[WIDTH-1]);
            end
         end
         DONE: state_d = out_ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         cnt_q        <= '0;
         borrow_q     <= 1'b0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         diff_q       <= diff_d;
         cnt_q        <= cnt_d;
         borrow_q     <= borrow_d;
         borrow_out_q <= borrow_out_d;
         overflow_q   <= overflow_d;
      end
   end

   assign in_ready_o   = state_q == IDLE;
   assign out_valid_o  = state_q == DONE;
   assign diff_o       = diff_q;
   assign borrow_out_o = borrow_out_q;
   assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_sub_16_bit_serial.sv
// tb_sub_16_bit_serial: randomized and directed checks of the serial subtractor against an arithmetic model.
module tb_sub_16_bit_serial;
   logic        clk, rst_n;
   logic [15:0] a, b, diff;
   logic        borrow_in, in_valid, in_ready, borrow_out, overflow, out_valid, out_ready;
   int          tests = 0, fails = 0;

   sub_16_bit_serial dut (
      .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .borrow_in_i(borrow_in),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .diff_o(diff),
      .borrow_out_o(borrow_out), .overflow_o(overflow), .out_valid_o(out_valid),
      .out_ready_i(out_ready)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [15:0] m_diff(input logic [15:0] x, y, input logic c);
      return x - y - 16'(c);
   endfunction
   function automatic logic m_borrow(input logic [15:0] x, y, input logic c);
      return int'(x) < int'(y) + int'(c);
   endfunction
   function automatic logic m_ovf(input logic [15:0] x, y, input logic c);
      int s;
      s = int'($signed(x)) - int'($signed(y)) - int'(c);
      return (s > 32767) || (s < -32768);
   endfunction

   // Runs one operation from a negedge; returns the result, latency in edges and whether it stayed stable under stall.
   task automatic op(input logic [15:0] ai, bi, input logic ci, input int stall,
                     output logic [15:0] d, output logic bo, ov, output int lat, output logic held);
      int w = 0;
      a = ai; b = bi; borrow_in = ci; in_valid = 1;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      @(negedge clk);
      in_valid = 0; a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      if (w >= 50) lat = -1;
      d = diff; bo = borrow_out; ov = overflow; held = 1;
      repeat (stall) begin
         @(negedge clk);
         if (diff !== d || borrow_out !== bo || overflow !== ov || out_valid !== 1'b1) held = 0;
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
   endtask

   task automatic test_reset;
      rst_n = 0; in_valid = 0; out_ready = 0; a = 0; b = 0; borrow_in = 0;
      #1;
      tests++;
      if ({diff, borrow_out, overflow, out_valid, in_ready} !== {16'h0, 4'b0001}) begin
         fails++;
         $display("FAIL reset: diff=%h bo=%b ov=%b ov_valid=%b in_ready=%b, want 0/0/0/0/1",
                  diff, borrow_out, overflow, out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_directed;
      logic [15:0] va[4] = '{16'h1234, 16'h0000, 16'h8000, 16'h1000};
      logic [15:0] vb[4] = '{16'h0234, 16'h0001, 16'h0001, 16'h0FFF};
      logic        vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] d;
      logic        bo, ov, held;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         op(va[i], vb[i], vc[i], 0, d, bo, ov, lat, held);
         tests++;
         if (d !== m_diff(va[i], vb[i], vc[i]) || bo !== m_borrow(va[i], vb[i], vc[i])
             || ov !== m_ovf(va[i], vb[i], vc[i])) begin
            fails++;
            $display("FAIL directed[%0d] %h-%h-%b: got %h/%b/%b want %h/%b/%b", i, va[i], vb[i], vc[i],
                     d, bo, ov, m_diff(va[i], vb[i], vc[i]), m_borrow(va[i], vb[i], vc[i]), m_ovf(va[i], vb[i], vc[i]));
         end
         tests++;
         if (lat !== 4) begin fails++; $display("FAIL latency[%0d]: got %0d want 4", i, lat); end
         tests++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL release[%0d]: in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] d0;
      logic        bo, ov, held;
      int          w = 0, lat;
      a = 16'h1234; b = 16'h0234; borrow_in = 0; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      d0 = diff;
      a = 16'hFFFF; b = 16'h0000; in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (diff !== 16'h1000 || borrow_out !== 1'b0 || overflow !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall[%0d]: diff=%h bo=%b ov=%b valid=%b in_ready=%b want 1000/0/0/1/0 (first %h)",
                     i, diff, borrow_out, overflow, out_valid, in_ready, d0);
         end
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL stall_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      op(16'hFFFF, 16'h0000, 1'b0, 0, d0, bo, ov, lat, held);
      tests++;
      if (d0 !== 16'hFFFF || bo !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
         fails++;
         $display("FAIL rehandshake: diff=%h bo=%b ov=%b lat=%0d want ffff/0/0/4", d0, bo, ov, lat);
      end
   endtask

   task automatic test_reset_mid_calc;
      logic [15:0] d;
      logic        bo, ov, held, seen;
      int          lat;
      a = 16'hABCD; b = 16'h1234; borrow_in = 1; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      rst_n = 0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || diff !== 16'h0 || in_ready !== 1'b1 || borrow_out !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: out_valid=%b diff=%h in_ready=%b bo=%b ov=%b want 0/0000/1/0/0",
                  out_valid, diff, in_ready, borrow_out, overflow);
      end
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (6) begin @(negedge clk); seen |= out_valid; end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL aborted_op: out_valid=%b want 0", seen); end
      op(16'h0005, 16'h0003, 1'b0, 0, d, bo, ov, lat, held);
      tests++;
      if (d !== 16'h0002 || bo !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
         fails++;
         $display("FAIL after_reset: diff=%h bo=%b ov=%b lat=%0d want 0002/0/0/4", d, bo, ov, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] x, y, d;
      logic        c, bo, ov, held;
      int          lat, st;
      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
         if (i % 10 == 0) y = x;
         st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         op(x, y, c, st, d, bo, ov, lat, held);
         tests++;
         if (d !== m_diff(x, y, c) || bo !== m_borrow(x, y, c) || ov !== m_ovf(x, y, c) || lat !== 4 || held !== 1'b1) begin
            fails++;
            $display("FAIL random[%0d] %h-%h-%b: got %h/%b/%b lat=%0d held=%b want %h/%b/%b lat=4 held=1",
                     i, x, y, c, d, bo, ov, lat, held, m_diff(x, y, c), m_borrow(x, y, c), m_ovf(x, y, c));
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_reset_mid_calc;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
